// File: rtl/aes_output_serializer_if.sv
// ----------------------------------------------------------------------------
// aes_output_serializer_if
//
// Purpose:
//     Groups the block-input handshake and the word-output stream of the AES
//     output serializer into one bundle. Widths follow the same block/word
//     parameters as the serializer.
//
// Signals:
//     done_i      block on text_in is complete (input valid)
//     text_in     block to serialise, captured on accept
//     in_ready_o  serializer can take a block this cycle
//     clear_i     synchronous abort of active and pending blocks
//     text_o      current output word
//     done_o      output word valid
//     ready_i     downstream ready
//     last_o      text_o is the final word of its block
//     word_idx_o  index of the current word in emission order
//     busy_o      active or pending block present
//
// Modports:
//     master  block source / word sink side (core datapath, testbench)
//     slave   the serializer itself
// ----------------------------------------------------------------------------
interface aes_output_serializer_if #(
    parameter int BLOCK_W = 128,
    parameter int WORD_W  = 32
);
    localparam int NWORDS = BLOCK_W / WORD_W;
    localparam int IDX_W  = (NWORDS > 2) ? $clog2(NWORDS) : 1;

    logic               done_i;
    logic [BLOCK_W-1:0] text_in;
    logic               in_ready_o;
    logic               clear_i;
    logic [WORD_W-1:0]  text_o;
    logic               done_o;
    logic               ready_i;
    logic               last_o;
    logic [IDX_W-1:0]   word_idx_o;
    logic               busy_o;

    modport master (
        output done_i,
        output text_in,
        input  in_ready_o,
        output clear_i,
        input  text_o,
        input  done_o,
        output ready_i,
        input  last_o,
        input  word_idx_o,
        input  busy_o
    );

    modport slave (
        input  done_i,
        input  text_in,
        output in_ready_o,
        input  clear_i,
        output text_o,
        output done_o,
        input  ready_i,
        output last_o,
        output word_idx_o,
        output busy_o
    );
endinterface

// File: rtl/aes_output_serializer.sv
// ----------------------------------------------------------------------------
// aes_output_serializer
//
// Purpose:
//     Takes a completed BLOCK_W-bit cipher/plain block from the AES round
//     datapath and emits it as NWORDS words of WORD_W bits with ready/valid
//     backpressure. A one-block pending register lets the core hand over the
//     next block while the current one is still draining, so back-to-back
//     blocks stream with no bubble.
//
// Parameters:
//     BLOCK_W    input block width (integer multiple of WORD_W)
//     WORD_W     output word width
//     MSW_FIRST  0: least-significant word first, 1: most-significant first
//
// Ports:
//     clk   system clock, rising edge
//     rst   asynchronous, active-low reset
//     bus   slave side of aes_output_serializer_if (block input handshake,
//           abort, word output stream, status)
// ----------------------------------------------------------------------------
module aes_output_serializer #(
    parameter int BLOCK_W   = 128,
    parameter int WORD_W    = 32,
    parameter bit MSW_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_output_serializer_if.slave bus
);
    localparam int NWORDS = BLOCK_W / WORD_W;
    localparam int IDX_W  = (NWORDS > 2) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    // Elaboration-time sanity checks on the geometry.
    if ((BLOCK_W % WORD_W) != 0) begin : g_bad_ratio
        $error("aes_output_serializer: BLOCK_W must be a multiple of WORD_W");
    end
    if (NWORDS < 2) begin : g_too_few_words
        $error("aes_output_serializer: at least two words per block required");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [NWORDS-1:0][WORD_W-1:0] words_t;

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] active_q, active_d;
    logic [BLOCK_W-1:0] pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  text_q, text_d;
    logic               done_q, done_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic               xfer;
    logic               cnt_last;
    logic [IDX_W-1:0]   word_sel;
    words_t             active_words;

    // in_ready depends only on registered state, so there is no
    // combinational path from ready_i back to the block source.
    assign accept   = bus.done_i && !pend_valid_q;
    assign xfer     = done_q && bus.ready_i;
    assign cnt_last = (cnt_q == LAST_IDX);

    // Next-state logic. All outputs are computed from the next state so that
    // they come straight out of flops and react to reset asynchronously.
    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;

        if (bus.clear_i) begin
            // Abort wins over any accept or transfer in the same cycle.
            state_d      = IDLE;
            pend_valid_d = 1'b0;
            cnt_d        = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        active_d = bus.text_in;
                        cnt_d    = '0;
                        state_d  = SEND;
                    end
                end
                SEND: begin
                    if (xfer && cnt_last) begin
                        // Block boundary: refill from pending first, else
                        // from a block arriving right now, else go idle.
                        cnt_d = '0;
                        if (pend_valid_q) begin
                            active_d     = pend_q;
                            pend_valid_d = 1'b0;
                        end else if (accept) begin
                            active_d = bus.text_in;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            cnt_d = cnt_q + IDX_W'(1);
                        end
                        if (accept) begin
                            pend_d       = bus.text_in;
                            pend_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (MSW_FIRST) begin
            word_sel = LAST_IDX - cnt_d;
        end else begin
            word_sel = cnt_d;
        end

        active_words = active_d;
        done_d       = (state_d == SEND);
        text_d       = done_d ? active_words[word_sel] : '0;
        last_d       = done_d && (cnt_d == LAST_IDX);
        busy_d       = done_d || pend_valid_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            active_q     <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
            text_q       <= '0;
            done_q       <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
            text_q       <= text_d;
            done_q       <= done_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.in_ready_o = !pend_valid_q;
    assign bus.text_o     = text_q;
    assign bus.done_o     = done_q;
    assign bus.last_o     = last_q;
    assign bus.word_idx_o = cnt_q;
    assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_aes_output_serializer.sv
// ----------------------------------------------------------------------------
// tb_aes_output_serializer
//
// Purpose:
//     Directed bench for aes_output_serializer. Four instances are used:
//     dut_a  128/32, LSW first (main instance)
//     dut_b  128/32, MSW first
//     dut_c  256/64, LSW first
//     dut_d  64/32,  LSW first (two words, one-bit word index)
//
// Ports:
//     none (top-level bench)
// ----------------------------------------------------------------------------
module tb_aes_output_serializer;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;

    localparam logic [127:0] BLK_BASIC = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] BLK_B     = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
    localparam logic [127:0] BLK_C     = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
    localparam logic [255:0] BLK_WIDE  =
        256'h44444444_44444444_33333333_33333333_22222222_22222222_11111111_11111111;
    localparam logic [63:0]  BLK_SMALL = 64'hDEADBEEF_01234567;

    aes_output_serializer_if #(.BLOCK_W(128), .WORD_W(32)) bus_a ();
    aes_output_serializer_if #(.BLOCK_W(128), .WORD_W(32)) bus_b ();
    aes_output_serializer_if #(.BLOCK_W(256), .WORD_W(64)) bus_c ();
    aes_output_serializer_if #(.BLOCK_W(64),  .WORD_W(32)) bus_d ();

    aes_output_serializer #(.BLOCK_W(128), .WORD_W(32), .MSW_FIRST(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    aes_output_serializer #(.BLOCK_W(128), .WORD_W(32), .MSW_FIRST(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    aes_output_serializer #(.BLOCK_W(256), .WORD_W(64), .MSW_FIRST(1'b0)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (bus_c.slave)
    );

    aes_output_serializer #(.BLOCK_W(64), .WORD_W(32), .MSW_FIRST(1'b0)) dut_d (
        .clk (clk),
        .rst (rst),
        .bus (bus_d.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives the block-input side of the main instance.
    task automatic applyStimulus(input logic done, input logic [127:0] blk);
        bus_a.done_i  = done;
        bus_a.text_in = blk;
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_words[4];
        logic [63:0] exp_wide[4];
        logic [31:0] exp_small[2];

        exp_words = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333};
        exp_wide  = '{64'h11111111_11111111, 64'h22222222_22222222,
                      64'h33333333_33333333, 64'h44444444_44444444};
        exp_small = '{32'h01234567, 32'hDEADBEEF};

        tests_run    = 0;
        tests_failed = 0;

        rst = 1'b1;
        applyStimulus(1'b0, '0);
        bus_a.clear_i = 1'b0; bus_a.ready_i = 1'b1;
        bus_b.done_i = 1'b0; bus_b.text_in = '0; bus_b.clear_i = 1'b0; bus_b.ready_i = 1'b1;
        bus_c.done_i = 1'b0; bus_c.text_in = '0; bus_c.clear_i = 1'b0; bus_c.ready_i = 1'b1;
        bus_d.done_i = 1'b0; bus_d.text_in = '0; bus_d.clear_i = 1'b0; bus_d.ready_i = 1'b1;

        // ---- reset state ----
        #1 rst = 1'b0;
        #1;
        checkOutput("rst_done",     bus_a.done_o,     0);
        checkOutput("rst_text",     bus_a.text_o,     0);
        checkOutput("rst_last",     bus_a.last_o,     0);
        checkOutput("rst_idx",      bus_a.word_idx_o, 0);
        checkOutput("rst_busy",     bus_a.busy_o,     0);
        checkOutput("rst_in_ready", bus_a.in_ready_o, 1);
        checkOutput("rst_d_ready",  bus_d.in_ready_o, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // ---- basic order (dut_a) and reverse order (dut_b) ----
        applyStimulus(1'b1, BLK_BASIC);
        bus_b.done_i  = 1'b1;
        bus_b.text_in = BLK_BASIC;
        tick();
        applyStimulus(1'b0, '0);
        bus_b.done_i  = 1'b0;
        bus_b.text_in = '0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("basic_done", bus_a.done_o,     1);
            checkOutput("basic_text", bus_a.text_o,     exp_words[i]);
            checkOutput("basic_idx",  bus_a.word_idx_o, i);
            checkOutput("basic_last", bus_a.last_o,     (i == 3));
            checkOutput("rev_text",   bus_b.text_o,     exp_words[3-i]);
            checkOutput("rev_idx",    bus_b.word_idx_o, i);
            checkOutput("rev_last",   bus_b.last_o,     (i == 3));
            tick();
        end
        checkOutput("basic_idle_done", bus_a.done_o, 0);
        checkOutput("basic_idle_text", bus_a.text_o, 0);
        checkOutput("basic_idle_busy", bus_a.busy_o, 0);
        checkOutput("rev_idle_done",   bus_b.done_o, 0);
        tick();

        // ---- backpressure on word 1 ----
        applyStimulus(1'b1, BLK_BASIC);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("bp_w0", bus_a.text_o, 32'h00000000);
        tick();
        checkOutput("bp_w1", bus_a.text_o, 32'h11111111);
        bus_a.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_hold_text", bus_a.text_o,     32'h11111111);
            checkOutput("bp_hold_idx",  bus_a.word_idx_o, 1);
            checkOutput("bp_hold_done", bus_a.done_o,     1);
            checkOutput("bp_hold_last", bus_a.last_o,     0);
        end
        bus_a.ready_i = 1'b1;
        tick();
        checkOutput("bp_w2",      bus_a.text_o, 32'h22222222);
        checkOutput("bp_w2_idx",  bus_a.word_idx_o, 2);
        tick();
        checkOutput("bp_w3",      bus_a.text_o, 32'h33333333);
        checkOutput("bp_w3_last", bus_a.last_o, 1);
        tick();
        checkOutput("bp_idle",    bus_a.done_o, 0);
        tick();

        // ---- back-to-back blocks, then a direct load at the boundary ----
        applyStimulus(1'b1, BLK_BASIC);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("b2b_a_w0",       bus_a.text_o,     32'h00000000);
        checkOutput("b2b_a_w0_ready", bus_a.in_ready_o, 1);
        tick();
        checkOutput("b2b_a_w1", bus_a.text_o, 32'h11111111);
        applyStimulus(1'b1, BLK_B);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("b2b_a_w2",       bus_a.text_o,     32'h22222222);
        checkOutput("b2b_a_w2_ready", bus_a.in_ready_o, 0);
        checkOutput("b2b_a_w2_busy",  bus_a.busy_o,     1);
        tick();
        checkOutput("b2b_a_w3",       bus_a.text_o,     32'h33333333);
        checkOutput("b2b_a_w3_last",  bus_a.last_o,     1);
        checkOutput("b2b_a_w3_ready", bus_a.in_ready_o, 0);
        tick();
        checkOutput("b2b_b_w0",       bus_a.text_o,     32'hAAAAAAAA);
        checkOutput("b2b_b_w0_done",  bus_a.done_o,     1);
        checkOutput("b2b_b_w0_idx",   bus_a.word_idx_o, 0);
        checkOutput("b2b_b_w0_last",  bus_a.last_o,     0);
        checkOutput("b2b_b_w0_ready", bus_a.in_ready_o, 1);
        for (int j = 1; j < 4; j++) begin
            tick();
            checkOutput("b2b_b_text", bus_a.text_o,     32'hAAAAAAAA);
            checkOutput("b2b_b_done", bus_a.done_o,     1);
            checkOutput("b2b_b_idx",  bus_a.word_idx_o, j);
        end
        checkOutput("b2b_b_last", bus_a.last_o, 1);
        applyStimulus(1'b1, BLK_C);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("direct_w0",      bus_a.text_o,     32'hCCCC0000);
        checkOutput("direct_w0_done", bus_a.done_o,     1);
        checkOutput("direct_w0_idx",  bus_a.word_idx_o, 0);
        checkOutput("direct_w0_rdy",  bus_a.in_ready_o, 1);
        tick();
        tick();
        tick();
        checkOutput("direct_w3",      bus_a.text_o, 32'hCCCC0003);
        checkOutput("direct_w3_last", bus_a.last_o, 1);
        tick();
        checkOutput("direct_idle",    bus_a.done_o, 0);
        tick();

        // ---- abort with a pending block ----
        applyStimulus(1'b1, BLK_BASIC);
        tick();
        applyStimulus(1'b1, BLK_B);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("clr_w1",       bus_a.text_o,     32'h11111111);
        checkOutput("clr_pend_rdy", bus_a.in_ready_o, 0);
        tick();
        checkOutput("clr_w2_idx", bus_a.word_idx_o, 2);
        bus_a.clear_i = 1'b1;
        applyStimulus(1'b1, BLK_C);
        tick();
        checkOutput("clr_done",  bus_a.done_o,     0);
        checkOutput("clr_busy",  bus_a.busy_o,     0);
        checkOutput("clr_ready", bus_a.in_ready_o, 1);
        checkOutput("clr_text",  bus_a.text_o,     0);
        checkOutput("clr_idx",   bus_a.word_idx_o, 0);
        // Accept offered while clear is held with in_ready high is dropped.
        tick();
        checkOutput("clr_drop_done", bus_a.done_o, 0);
        checkOutput("clr_drop_busy", bus_a.busy_o, 0);
        bus_a.clear_i = 1'b0;
        applyStimulus(1'b0, '0);
        tick();
        checkOutput("clr_after_done", bus_a.done_o, 0);

        // ---- asynchronous reset mid-block ----
        applyStimulus(1'b1, BLK_BASIC);
        tick();
        applyStimulus(1'b0, '0);
        tick();
        checkOutput("arst_pre_w1", bus_a.text_o, 32'h11111111);
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_done",  bus_a.done_o,     0);
        checkOutput("arst_text",  bus_a.text_o,     0);
        checkOutput("arst_idx",   bus_a.word_idx_o, 0);
        checkOutput("arst_busy",  bus_a.busy_o,     0);
        checkOutput("arst_ready", bus_a.in_ready_o, 1);
        #2 rst = 1'b1;
        tick();
        checkOutput("arst_after_done", bus_a.done_o, 0);
        tick();
        checkOutput("arst_after2_done", bus_a.done_o, 0);

        // ---- width generalisation: 256/64 and 64/32 ----
        bus_c.done_i  = 1'b1;
        bus_c.text_in = BLK_WIDE;
        bus_d.done_i  = 1'b1;
        bus_d.text_in = BLK_SMALL;
        tick();
        bus_c.done_i  = 1'b0;
        bus_c.text_in = '0;
        bus_d.done_i  = 1'b0;
        bus_d.text_in = '0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("wide_text", bus_c.text_o,     exp_wide[i]);
            checkOutput("wide_idx",  bus_c.word_idx_o, i);
            checkOutput("wide_last", bus_c.last_o,     (i == 3));
            if (i < 2) begin
                checkOutput("small_text", bus_d.text_o,     exp_small[i]);
                checkOutput("small_idx",  bus_d.word_idx_o, i);
                checkOutput("small_last", bus_d.last_o,     (i == 1));
                checkOutput("small_done", bus_d.done_o,     1);
            end else begin
                checkOutput("small_idle", bus_d.done_o, 0);
            end
            tick();
        end
        checkOutput("wide_idle", bus_c.done_o, 0);
        checkOutput("wide_busy", bus_c.busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
